// File: rtl/failure_log.sv
// Failure event logger: stamps each checker failure with the cycle count into a
// small FIFO, keeps a saturating event count and raises a sticky alarm at THRESH.
module failure_log #(
    parameter int DW        = 32,
    parameter int CNT_W     = 16,
    parameter int DEPTH     = 4,
    parameter int THRESH    = 8,
    parameter int EDGE_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             failure_i,
    input  logic [DW-1:0]    sig_i,
    input  logic             clear_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] rd_cyc_o,
    output logic [DW-1:0]    rd_sig_o,
    output logic [CNT_W-1:0] fail_count_o,
    output logic             overflow_o,
    output logic             alarm_o,
    output logic [CNT_W-1:0] cyc_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    typedef enum logic [1:0] {IDLE, LOGGING, ALARM} state_t;

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cyc_q, cnt_q, cnt_inc;
    logic                         prev_fail, ovf_q;
    logic [AW:0]                  wr_ptr, rd_ptr;
    logic [DEPTH-1:0][CNT_W-1:0]  mem_cyc;
    logic [DEPTH-1:0][DW-1:0]     mem_sig;
    logic                         event_w, empty, full, push, pop;

    assign event_w = failure_i & ((EDGE_MODE == 0) | ~prev_fail);
    assign empty   = (wr_ptr == rd_ptr);
    // Wrap bits differ with equal indices: writer is a full lap ahead.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = ~empty & rd_ready_i;
    assign push    = event_w & (~full | pop);
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q     <= '0;
            cnt_q     <= '0;
            prev_fail <= 1'b0;
            ovf_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cyc   <= '0;
            mem_sig   <= '0;
        end else begin
            cyc_q     <= cyc_q + 1'b1;
            prev_fail <= failure_i;
            if (clear_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (push) begin
                    mem_cyc[wr_ptr[AW-1:0]] <= cyc_q;
                    mem_sig[wr_ptr[AW-1:0]] <= sig_i;
                    wr_ptr                  <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (event_w) begin
                    cnt_q <= cnt_inc;
                    if (full && !pop)
                        ovf_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // IDLE and LOGGING share the same exit test so THRESH=1 jumps straight to ALARM.
    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = IDLE;
        end else if (event_w) begin
            case (state)
                IDLE, LOGGING: state_nxt = (cnt_inc == THRESH_C) ? ALARM : LOGGING;
                ALARM:         state_nxt = ALARM;
                default:       state_nxt = IDLE;
            endcase
        end
    end

    assign rd_valid_o   = ~empty;
    assign rd_cyc_o     = mem_cyc[rd_ptr[AW-1:0]];
    assign rd_sig_o     = mem_sig[rd_ptr[AW-1:0]];
    assign fail_count_o = cnt_q;
    assign overflow_o   = ovf_q;
    assign alarm_o      = (state == ALARM);
    assign cyc_o        = cyc_q;

endmodule

// File: tb/tb_failure_log.sv
// Scoreboard bench for failure_log: a default-parameter instance (level events)
// and a narrow EDGE_MODE instance used for edge detection, saturation and wrap.
module tb_failure_log;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        f0 = 0, clr0 = 0, rdy0 = 0;
    logic [31:0] s0 = '0;
    logic        rv0, ovf0, al0;
    logic [15:0] rc0, cnt0, cyc0;
    logic [31:0] rs0;

    logic        f1 = 0, c1 = 0, r1 = 0;
    logic [7:0]  s1 = '0;
    logic        rv1, ovf1, al1;
    logic [3:0]  rc1, cnt1, cyc1;
    logic [7:0]  rs1;

    failure_log #(.DW(32), .CNT_W(16), .DEPTH(4), .THRESH(8), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .failure_i(f0), .sig_i(s0), .clear_i(clr0),
        .rd_ready_i(rdy0), .rd_valid_o(rv0), .rd_cyc_o(rc0), .rd_sig_o(rs0),
        .fail_count_o(cnt0), .overflow_o(ovf0), .alarm_o(al0), .cyc_o(cyc0));

    failure_log #(.DW(8), .CNT_W(4), .DEPTH(4), .THRESH(3), .EDGE_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .failure_i(f1), .sig_i(s1), .clear_i(c1),
        .rd_ready_i(r1), .rd_valid_o(rv1), .rd_cyc_o(rc1), .rd_sig_o(rs1),
        .fail_count_o(cnt1), .overflow_o(ovf1), .alarm_o(al1), .cyc_o(cyc1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference cycle counters, expected log queues and counters
    logic [15:0] m0_cyc;
    logic [3:0]  m1_cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_cyc <= '0;
            m1_cyc <= '0;
        end else begin
            m0_cyc <= m0_cyc + 16'd1;
            m1_cyc <= m1_cyc + 4'd1;
        end
    end

    logic [47:0] q0[$];
    logic [11:0] q1[$];
    int m0_cnt = 0, m1_cnt = 0;
    bit m0_ovf = 0, m0_al = 0, m1_ovf = 0, m1_prev = 0;

    task automatic step0(input logic f, input logic [31:0] s, input logic clr, input logic rdy);
        logic [47:0] e;
        f0 = f; s0 = s; clr0 = clr; rdy0 = rdy;
        if (!clr && rdy && q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0_pop_valid", rv0, 1);
            chk("d0_pop_cyc", rc0, e[47:32]);
            chk("d0_pop_sig", rs0, e[31:0]);
        end
        if (clr) begin
            q0.delete(); m0_cnt = 0; m0_ovf = 0; m0_al = 0;
        end else if (f) begin
            if (q0.size() < 4) q0.push_back({m0_cyc, s});
            else               m0_ovf = 1;
            if (m0_cnt < 65535) m0_cnt++;
            if (m0_cnt >= 8)    m0_al = 1;
        end
        @(posedge clk); #1;
        chk("d0_valid", rv0, q0.size() > 0);
        chk("d0_count", cnt0, m0_cnt);
        chk("d0_overflow", ovf0, m0_ovf);
        chk("d0_alarm", al0, m0_al);
        chk("d0_cyc", cyc0, m0_cyc);
    endtask

    task automatic step1(input logic f, input logic [7:0] s, input logic clr, input logic rdy);
        logic [11:0] e;
        bit ev;
        f1 = f; s1 = s; c1 = clr; r1 = rdy;
        ev = f & ~m1_prev;
        if (!clr && rdy && q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1_pop_valid", rv1, 1);
            chk("d1_pop_cyc", rc1, e[11:8]);
            chk("d1_pop_sig", rs1, e[7:0]);
        end
        if (clr) begin
            q1.delete(); m1_cnt = 0; m1_ovf = 0;
        end else if (ev) begin
            if (q1.size() < 4) q1.push_back({m1_cyc, s});
            else               m1_ovf = 1;
            if (m1_cnt < 15) m1_cnt++;
        end
        m1_prev = f;
        @(posedge clk); #1;
        chk("d1_valid", rv1, q1.size() > 0);
        chk("d1_count", cnt1, m1_cnt);
        chk("d1_overflow", ovf1, m1_ovf);
        chk("d1_alarm", al1, m1_cnt >= 3);
        chk("d1_cyc", cyc1, m1_cyc);
    endtask

    initial begin
        logic [7:0] pat;
        pat = 8'b1001_1111;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", rv0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_alarm", al0, 0);
        chk("rst_cyc", cyc0, 0);
        @(negedge clk) rst_n = 1'b1;

        // First event at cyc=5
        repeat (5) step0(0, '0, 0, 0);
        step0(1, 32'h3, 0, 0);
        chk("t2_rd_cyc", rc0, 16'd5);
        chk("t2_rd_sig", rs0, 32'h3);
        chk("t2_count", cnt0, 1);
        chk("t2_alarm", al0, 0);

        // Async reset mid-run with 3 entries logged
        step0(1, 32'h11, 0, 0);
        step0(1, 32'h12, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_valid", rv0, 0);
        chk("t1_rd_cyc", rc0, 0);
        chk("t1_rd_sig", rs0, 0);
        chk("t1_count", cnt0, 0);
        chk("t1_overflow", ovf0, 0);
        chk("t1_alarm", al0, 0);
        chk("t1_cyc", cyc0, 0);
        q0.delete(); m0_cnt = 0; m0_ovf = 0; m0_al = 0;
        f0 = 0;
        @(negedge clk) rst_n = 1'b1;

        // Fill past depth, then push+pop while full, then drain all four
        for (int i = 0; i < 6; i++) step0(1, 32'hA0 + i, 0, 0);
        chk("t3_overflow", ovf0, 1);
        chk("t3_count", cnt0, 6);
        step0(1, 32'hB0, 0, 1);
        repeat (4) step0(0, '0, 0, 1);
        chk("t3_drained", rv0, 0);

        // Alarm threshold, stickiness, clear
        chk("t4_alarm_at7", al0, 0);
        step0(1, 32'hC0, 0, 0);
        chk("t4_alarm_at8", al0, 1);
        repeat (3) step0(0, '0, 0, 0);
        chk("t4_alarm_sticky", al0, 1);
        step0(0, '0, 1, 0);
        chk("t4_clr_alarm", al0, 0);
        chk("t4_clr_count", cnt0, 0);
        chk("t4_clr_valid", rv0, 0);

        // Read while empty, level-mode pattern with reads enabled
        repeat (2) step0(0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step0(pat[i], 32'hD0 + i, 0, 1);
        repeat (2) step0(0, '0, 0, 1);
        chk("t5_level_count", cnt0, 6);

        // Clear wins over a same-cycle event
        step0(1, 32'hEE, 1, 0);
        chk("t6_clr_ev_count", cnt0, 0);
        chk("t6_clr_ev_valid", rv0, 0);
        f0 = 0; clr0 = 0; rdy0 = 0;

        // Edge mode: same pattern gives two events stamped at the rising edges
        step1(0, '0, 1, 0);
        for (int i = 0; i < 8; i++) step1(pat[i], 8'h10 + 8'(i), 0, 0);
        chk("t5_edge_count", cnt1, 2);
        repeat (2) step1(0, '0, 0, 1);

        // Reach alarm then saturate the 4-bit count with FIFO overflow
        for (int i = 0; i < 16; i++) begin
            step1(1, 8'h40 + 8'(i), 0, 0);
            step1(0, '0, 0, 0);
        end
        chk("t6_sat_count", cnt1, 4'hF);
        chk("t6_sat_overflow", ovf1, 1);
        chk("t6_sat_alarm", al1, 1);
        repeat (4) step1(0, '0, 0, 1);

        // Stamps across the cycle-counter wrap, consumer keeping up
        step1(0, '0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            step1(1, 8'h80 + 8'(i), 0, 1);
            step1(0, '0, 0, 1);
        end
        repeat (2) step1(0, '0, 0, 1);

        // Clear with event; prev_fail still tracks, so holding high is no event
        step1(1, 8'hEE, 1, 0);
        chk("t6_d1_clr_count", cnt1, 0);
        chk("t6_d1_clr_valid", rv1, 0);
        step1(1, 8'hEF, 0, 0);
        chk("t6_d1_no_edge", cnt1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
